sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Upstream write-side stage for the 640x480, 3-bit palette-index frame buffer.
- Copies a rectangular sprite from a synchronous sprite ROM into frame-buffer write transactions, or fills a rectangle with a constant index.
- Turns one start request into a burst of per-pixel writes (we / write_address / data_In) for the frame RAM.
- Index 0 is the transparency key in copy mode.

Parameters:
SCREEN_W, 640, frame width in pixels
SCREEN_H, 480, frame height in pixels
ADDR_W, 20, frame-buffer address width
PIX_W, 3, palette index width
DIM_W, 6, sprite width/height field width (max 63)
ROM_ADDR_W, 12, sprite ROM address width
TRANSPARENT, 0, index skipped in copy mode

Ports:
Clk  in  1  system clock, all state on rising edge
Reset_n  in  1  asynchronous, active-low reset
start  in  1  request pulse, sampled only in IDLE
mode  in  1  0 = copy from ROM, 1 = fill with fill_color
fill_color  in  PIX_W  fill index (mode 1)
x0  in  10  left column of rectangle
y0  in  10  top row of rectangle
w  in  DIM_W  rectangle width in pixels
h  in  DIM_W  rectangle height in pixels
rom_base  in  ROM_ADDR_W  ROM address of sprite pixel (0,0); row-major, stride w
rom_addr  out  ROM_ADDR_W  sprite ROM read address
rom_data  in  PIX_W  ROM data, valid 1 cycle after rom_addr
fb_we  out  1  frame-buffer write enable
fb_write_address  out  ADDR_W  frame-buffer write address, row*SCREEN_W+col
fb_data_In  out  PIX_W  frame-buffer write data
busy  out  1  high from start acceptance until done
done  out  1  one-cycle completion pulse

Behaviour:
- Reset values (asynchronous, immediate, also mid-burst): state IDLE; fb_we, busy, done, rom_addr, fb_write_address, fb_data_In = 0. An interrupted burst is abandoned and not resumed.
- States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE: on start=1, latch x0, y0, w, h, mode, fill_color, rom_base; set busy.
  - If w==0 or h==0, go directly to DONE with no writes.
  - Otherwise go to ISSUE with col=0, row=0, row_base=y0*SCREEN_W+x0, computed as (y0<<9)+(y0<<7)+x0 (no multiplier).
- ISSUE: one pixel per cycle; drive rom_addr = rom_base + row*w + col, tracked incrementally.
  - col wraps to 0 at w-1 and increments row; row_base += SCREEN_W.
  - After pixel (w-1, h-1) is issued, go to DRAIN.
- Write stage, one cycle behind issue: a pixel issued in cycle t is written in cycle t+1.
  - fb_write_address = row_base + col, delayed to match; fb_data_In = rom_data (mode 0) or fill_color (mode 1).
  - fb_we=1 unless mode 0 and rom_data==TRANSPARENT.
  - Fill mode writes every pixel, including index 0.
- DRAIN: one cycle for the last write; then DONE.
- DONE: done=1 for exactly one cycle, busy drops in the same cycle, then IDLE.
- A start in the DONE cycle is ignored. A start is accepted the cycle after done at the earliest.
- Timing: busy high for w*h+2 cycles for nonzero size; 1 cycle (DONE only) for zero size.
- start while busy: ignored. Inputs may change freely after acceptance.
- Width rules: fb address arithmetic is ADDR_W unsigned, wrapping modulo 2^ADDR_W. ROM address wraps modulo 2^ROM_ADDR_W.
- fb_we is never asserted outside ISSUE/DRAIN. Outputs other than done/busy hold their last value when fb_we=0.

Optional Feature:
- Macro BLIT_CLIP_EN.
- Defined: per-pixel clip. Any pixel with x0+col >= SCREEN_W or y0+row >= SCREEN_H gets fb_we=0. The ROM is still stepped, and cycle count is unchanged.
- Undefined: no clipping logic. The caller guarantees the rectangle is on-screen; off-screen pixels write to wrapped, unspecified addresses.

Decomposition:
- Shared package blit_pkg:
  - constants SCREEN_W, SCREEN_H, ADDR_W, PIX_W, TRANSPARENT;
  - typedef pix_t (logic [PIX_W-1:0]);
  - typedef fb_addr_t (logic [ADDR_W-1:0]);
  - enum blit_state_t {IDLE, ISSUE, DRAIN, DONE};
  - enum blit_mode_t {COPY, FILL}.
- One natural sub-module, blit_addr_gen: the col/row counters, row_base and ROM-address incrementers, and last-pixel flag. The top level holds the FSM and the delayed write stage.

Test Plan:
- Reset, then start copy x0=0, y0=0, w=2, h=2, rom_base=0x010, ROM={1,2,3,4} -> writes (0,1),(1,2),(640,3),(641,4) on consecutive cycles starting 2 cycles after start; busy 6 cycles; single done pulse.
- Copy w=3, h=1 at x0=10, y0=1, ROM={5,0,6} -> writes only addr 650 (data 5) and 652 (data 6); fb_we low on the middle cycle.
- Fill mode, fill_color=0, x0=639, y0=479, w=1, h=1 -> one write, addr 307199, data 0; done 3 cycles after start.
- w=0, h=5 start -> no fb_we, done 1 cycle after acceptance; a second start during busy of a 4x4 copy -> ignored, exactly 16 write cycles.
- Reset_n low mid-burst (8th pixel of a 4x4 fill) -> fb_we, busy, done drop at once; after release, a new 1x1 start completes normally.
- BLIT_CLIP_EN defined, fill x0=638, y0=0, w=4, h=1 -> writes only addrs 638 and 639; busy still 6 cycles.

Source files
------------

// File: rtl/blit_pkg.sv
// blit_pkg: shared constants, types and state/mode encodings for the sprite blitter
package blit_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ADDR_W = 20;
  localparam int PIX_W = 3;
  localparam int DIM_W = 6;
  localparam int ROM_ADDR_W = 12;
  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;
  localparam pix_t TRANSPARENT = '0;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} blit_state_t;
  typedef enum logic {COPY, FILL} blit_mode_t;
endpackage

// File: rtl/blit_addr_gen.sv
// blit_addr_gen: col/row walk, row_base and ROM address incrementers, last-pixel and clip flags
// Ports: Clk, Reset_n; load (latch origin) / step (advance one pixel); x0, y0, w, h, rom_base;
// rom_addr, fb_addr (row_base+col of the current pixel), last, clip. Clip logic only under BLIT_CLIP_EN.
module blit_addr_gen
  import blit_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  load,
  input  logic                  step,
  input  logic [9:0]            x0,
  input  logic [9:0]            y0,
  input  logic [DIM_W-1:0]      w,
  input  logic [DIM_W-1:0]      h,
  input  logic [ROM_ADDR_W-1:0] rom_base,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  output fb_addr_t              fb_addr,
  output logic                  last,
  output logic                  clip
);
  logic [DIM_W-1:0] col, row;
  fb_addr_t row_base;
  logic col_end;
  assign col_end = col == w - 1'b1;
  assign last = col_end && row == h - 1'b1;
  assign fb_addr = row_base + fb_addr_t'(col);
  // row-major with stride w makes the ROM walk a plain +1 per pixel
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      col <= '0;
      row <= '0;
      row_base <= '0;
      rom_addr <= '0;
    end else if (load) begin
      col <= '0;
      row <= '0;
      row_base <= (fb_addr_t'(y0) << 9) + (fb_addr_t'(y0) << 7) + fb_addr_t'(x0);
      rom_addr <= rom_base;
    end else if (step) begin
      col <= col_end ? '0 : col + 1'b1;
      row <= col_end ? row + 1'b1 : row;
      row_base <= col_end ? row_base + fb_addr_t'(SCREEN_W) : row_base;
      rom_addr <= rom_addr + 1'b1;
    end
`ifdef BLIT_CLIP_EN
  logic [9:0] x0_q;
  logic [10:0] xc, yc;
  assign clip = xc >= 11'(SCREEN_W) || yc >= 11'(SCREEN_H);
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      x0_q <= '0;
      xc <= '0;
      yc <= '0;
    end else if (load) begin
      x0_q <= x0;
      xc <= {1'b0, x0};
      yc <= {1'b0, y0};
    end else if (step) begin
      xc <= col_end ? {1'b0, x0_q} : xc + 1'b1;
      yc <= col_end ? yc + 1'b1 : yc;
    end
`else
  assign clip = 1'b0;
`endif
endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: turns a start request into per-pixel frame-buffer writes (ROM copy or fill)
// Ports: Clk, Reset_n (async, active-low); start/mode/fill_color/x0/y0/w/h/rom_base request;
// rom_addr/rom_data sprite ROM (1-cycle latency); fb_we/fb_write_address/fb_data_In writes; busy, done.
// Optional per-pixel off-screen clipping with BLIT_CLIP_EN.
module sprite_blitter
  import blit_pkg::*;
(
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [PIX_W-1:0]      fill_color,
  input  logic [9:0]            x0,
  input  logic [9:0]            y0,
  input  logic [DIM_W-1:0]      w,
  input  logic [DIM_W-1:0]      h,
  input  logic [ROM_ADDR_W-1:0] rom_base,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]      rom_data,
  output logic                  fb_we,
  output logic [ADDR_W-1:0]     fb_write_address,
  output logic [PIX_W-1:0]      fb_data_In,
  output logic                  busy,
  output logic                  done
);
  blit_state_t state;
  blit_mode_t mode_q;
  pix_t fill_q, data_hold;
  fb_addr_t fb_addr, wr_addr, addr_hold;
  logic [DIM_W-1:0] w_q, h_q;
  logic load, step, last, clip, clip_q, wr_v, zero;
  assign load = state == IDLE && start;
  assign step = state == ISSUE;
  assign zero = w == '0 || h == '0;
  blit_addr_gen u_gen (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .load(load),
    .step(step),
    .x0(x0),
    .y0(y0),
    .w(w_q),
    .h(h_q),
    .rom_base(rom_base),
    .rom_addr(rom_addr),
    .fb_addr(fb_addr),
    .last(last),
    .clip(clip)
  );
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      w_q <= '0;
      h_q <= '0;
      mode_q <= COPY;
      fill_q <= '0;
    end else
      case (state)
        IDLE: if (start) begin
          w_q <= w;
          h_q <= h;
          mode_q <= blit_mode_t'(mode);
          fill_q <= fill_color;
          busy <= 1'b1;
          done <= zero;
          state <= zero ? DONE : ISSUE;
        end
        ISSUE: if (last) state <= DRAIN;
        DRAIN: begin
          done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
  // write stage trails issue by one cycle so rom_data lines up with its address
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      wr_v <= 1'b0;
      wr_addr <= '0;
      clip_q <= 1'b0;
      addr_hold <= '0;
      data_hold <= '0;
    end else begin
      wr_v <= step;
      wr_addr <= fb_addr;
      clip_q <= clip;
      addr_hold <= fb_write_address;
      data_hold <= fb_data_In;
    end
  assign fb_we = wr_v && !clip_q && (mode_q == FILL || rom_data != TRANSPARENT);
  assign fb_write_address = fb_we ? wr_addr : addr_hold;
  assign fb_data_In = fb_we ? (mode_q == FILL ? fill_q : rom_data) : data_hold;
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: randomized and directed checks of sprite_blitter against a per-pixel reference model
module tb_sprite_blitter;
  logic Clk = 1'b0, Reset_n = 1'b0, start = 1'b0, mode = 1'b0;
  logic [2:0] fill_color = '0, rom_data = '0;
  logic [9:0] x0 = '0, y0 = '0;
  logic [5:0] w = '0, h = '0;
  logic [11:0] rom_base = '0, rom_addr;
  logic fb_we, busy, done;
  logic [19:0] fb_write_address;
  logic [2:0] fb_data_In;
  logic [2:0] rom_mem [4096];
  int exp_we [4096];
  int exp_addr [4096];
  int exp_data [4096];
  int total = 0, bad = 0;

  sprite_blitter dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .start(start),
    .mode(mode),
    .fill_color(fill_color),
    .x0(x0),
    .y0(y0),
    .w(w),
    .h(h),
    .rom_base(rom_base),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .fb_we(fb_we),
    .fb_write_address(fb_write_address),
    .fb_data_In(fb_data_In),
    .busy(busy),
    .done(done)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic scramble();
    mode = 1'($urandom);
    fill_color = 3'($urandom);
    x0 = 10'($urandom);
    y0 = 10'($urandom);
    w = 6'($urandom);
    h = 6'($urandom);
    rom_base = 12'($urandom);
  endtask

  // start issued in cycle 0; pixel p is expected on the write port in cycle p+2
  task automatic run_blit(input int x, input int y, input int ww, input int hh, input int md, input int fc, input int base);
    int n, tot, poke, p, d, off, ew;
    n = ww * hh;
    tot = n > 0 ? n + 2 : 1;
    poke = $urandom_range(1, tot);
    for (int r = 0; r < hh; r++)
      for (int c = 0; c < ww; c++) begin
        p = r * ww + c;
        d = md != 0 ? fc : int'(rom_mem[(base + p) % 4096]);
        off = 0;
`ifdef BLIT_CLIP_EN
        off = (x + c >= 640 || y + r >= 480) ? 1 : 0;
`endif
        exp_we[p] = (off == 0 && (md != 0 || d != 0)) ? 1 : 0;
        exp_addr[p] = ((y + r) * 640 + x + c) & 32'hFFFFF;
        exp_data[p] = d;
      end
    @(negedge Clk);
    mode = md[0];
    fill_color = 3'(fc);
    x0 = 10'(x);
    y0 = 10'(y);
    w = 6'(ww);
    h = 6'(hh);
    rom_base = 12'(base);
    start = 1'b1;
    for (int i = 1; i <= tot + 1; i++) begin
      @(negedge Clk);
      start = 1'b0;
      scramble();
      p = i - 2;
      ew = (p >= 0 && p < n) ? exp_we[p] : 0;
      chk("we", 32'(fb_we), 32'(ew));
      if (ew != 0) begin
        chk("addr", 32'(fb_write_address), 32'(exp_addr[p]));
        chk("data", 32'(fb_data_In), 32'(exp_data[p]));
      end
      chk("busy", 32'(busy), 32'(i <= tot));
      chk("done", 32'(done), 32'(i == tot));
      if (i == poke) start = 1'b1;
    end
    start = 1'b0;
  endtask

  initial begin
    int md, ww, hh, x, y;
    for (int i = 0; i < 4096; i++) rom_mem[i] = 3'($urandom_range(0, 7));
    repeat (2) @(negedge Clk);
    chk("rst_we", 32'(fb_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rom", 32'(rom_addr), 0);
    chk("rst_addr", 32'(fb_write_address), 0);
    chk("rst_data", 32'(fb_data_In), 0);
    Reset_n = 1'b1;
    rom_mem[12'h010] = 3'd1;
    rom_mem[12'h011] = 3'd2;
    rom_mem[12'h012] = 3'd3;
    rom_mem[12'h013] = 3'd4;
    run_blit(0, 0, 2, 2, 0, 0, 12'h010);
    rom_mem[12'h100] = 3'd5;
    rom_mem[12'h101] = 3'd0;
    rom_mem[12'h102] = 3'd6;
    run_blit(10, 1, 3, 1, 0, 0, 12'h100);
    run_blit(639, 479, 1, 1, 1, 0, 0);
    run_blit(5, 5, 0, 5, 0, 3, 0);
    run_blit(100, 200, 4, 4, 0, 0, 12'hFFA);
    run_blit(20, 30, 63, 2, 1, 7, 0);
`ifdef BLIT_CLIP_EN
    run_blit(638, 0, 4, 1, 1, 5, 0);
    run_blit(1000, 470, 5, 15, 0, 0, 77);
`endif
    @(negedge Clk);
    mode = 1'b1;
    fill_color = 3'd2;
    x0 = 10'd50;
    y0 = 10'd60;
    w = 6'd4;
    h = 6'd4;
    start = 1'b1;
    repeat (9) begin
      @(negedge Clk);
      start = 1'b0;
    end
    chk("mid_we", 32'(fb_we), 1);
    chk("mid_addr", 32'(fb_write_address), 60 * 640 + 50 + 640 + 3);
    Reset_n = 1'b0;
    #1;
    chk("arst_we", 32'(fb_we), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_addr", 32'(fb_write_address), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    run_blit(7, 8, 1, 1, 0, 0, 12'h011);
    for (int k = 0; k < 30; k++) begin
      md = int'($urandom_range(0, 1));
      ww = int'($urandom_range(0, 9));
      hh = int'($urandom_range(0, 9));
`ifdef BLIT_CLIP_EN
      x = int'($urandom_range(0, 1023));
      y = int'($urandom_range(0, 1023));
`else
      x = int'($urandom_range(0, 640 - ww));
      y = int'($urandom_range(0, 480 - hh));
`endif
      run_blit(x, y, ww, hh, md, int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
